// File: rtl/dm_scan_shift.sv
// Serial scan-chain shifter: loads a parallel word, shifts it out LSB first while
// capturing the returning chain bits, then presents the captured word with a Done pulse.
module dm_scan_shift #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start,
    input  logic             Abort,
    input  logic [WIDTH-1:0] ParallelIn,
    input  logic             ScanIn,
    output logic             ScanOut,
    output logic             ScanEn,
    output logic             Busy,
    output logic             Done,
    output logic [WIDTH-1:0] ParallelOut
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_nx;
    logic [WIDTH-1:0] sr, sr_nx, sr_shift, pout_nx;
    logic [CW-1:0]    cnt, cnt_nx;

    assign sr_shift = {ScanIn, sr[WIDTH-1:1]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            sr          <= '0;
            cnt         <= '0;
            ParallelOut <= '0;
        end else begin
            state       <= state_nx;
            sr          <= sr_nx;
            cnt         <= cnt_nx;
            ParallelOut <= pout_nx;
        end
    end

    always_comb begin
        state_nx = state;
        sr_nx    = sr;
        cnt_nx   = cnt;
        pout_nx  = ParallelOut;
        case (state)
            IDLE: begin
                if (Start && !Abort) begin
                    sr_nx    = ParallelIn;
                    cnt_nx   = '0;
                    state_nx = SHIFT;
                end
            end
            SHIFT: begin
                // Abort wins even on the final edge, so the capture never lands
                if (Abort) begin
                    state_nx = IDLE;
                end else begin
                    sr_nx  = sr_shift;
                    cnt_nx = cnt + CW'(1);
                    if (cnt == LAST) begin
                        pout_nx  = sr_shift;
                        state_nx = DONE;
                    end
                end
            end
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    assign ScanEn  = (state == SHIFT);
    assign ScanOut = ScanEn & sr[0];
    assign Busy    = (state != IDLE);
    assign Done    = (state == DONE);
endmodule

// File: doc/dm_scan_shift.md
DM_SCAN_SHIFT -- requirements
Module: dm_scan_shift

Interface
REQ-001: The block SHALL have parameter WIDTH, default 32, giving the scan chain length in bits; legal range is WIDTH >= 2.
REQ-002: The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003: The block SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-004: The block SHALL have port Start, input, 1 bit: request a scan transaction; sampled only in IDLE.
REQ-005: The block SHALL have port Abort, input, 1 bit: cancel any transaction in progress.
REQ-006: The block SHALL have port ParallelIn, input, WIDTH bits: the value to shift out; captured on the accepted Start edge.
REQ-007: The block SHALL have port ScanIn, input, 1 bit: serial data returned from the chain.
REQ-008: The block SHALL have port ScanOut, output, 1 bit: serial data driven to the chain, LSB first.
REQ-009: The block SHALL have port ScanEn, output, 1 bit: high in every shift cycle.
REQ-010: The block SHALL have port Busy, output, 1 bit: high whenever the state is not IDLE.
REQ-011: The block SHALL have port Done, output, 1 bit: one-cycle completion pulse.
REQ-012: The block SHALL have port ParallelOut, output, WIDTH bits: the last fully captured chain value, registered.

Function
REQ-013: The block SHALL implement a registered FSM with states IDLE, SHIFT and DONE.
REQ-014: In IDLE, if Start=1 and Abort=0 at an edge, the block SHALL load the shift register with ParallelIn, clear the bit counter, and enter SHIFT.
REQ-015: In SHIFT, the block SHALL drive ScanEn=1 and ScanOut = shift register bit 0, both combinationally from state.
REQ-016: At each SHIFT edge, the shift register SHALL update to {ScanIn, sr[WIDTH-1:1]} and the counter SHALL increment; the counter is $clog2(WIDTH) bits wide.
REQ-017: At the SHIFT edge where the counter equals WIDTH-1, the block SHALL load ParallelOut with {ScanIn, sr[WIDTH-1:1]} and enter DONE.
REQ-018: In DONE, the block SHALL assert Done=1 for exactly one cycle and then return to IDLE unconditionally.
REQ-019: Timing SHALL be: Start accepted at edge 0; ScanEn high for exactly WIDTH cycles (edges 1..WIDTH); ParallelOut valid and Done high during the cycle after edge WIDTH.
REQ-020: Start asserted in SHIFT or DONE SHALL be ignored and SHALL NOT be queued.
REQ-021: Abort=1 in SHIFT or DONE SHALL force IDLE at the next edge, suppress Done for the remainder of that cycle's transition, and leave ParallelOut unchanged.
REQ-022: If Start and Abort are both 1 in IDLE, Abort SHALL win and the block SHALL remain in IDLE.
REQ-023: Abort on the final SHIFT edge (counter = WIDTH-1) SHALL win: no ParallelOut update, no Done.
REQ-024: Outside SHIFT, ScanOut and ScanEn SHALL be 0.
REQ-025: Outside DONE, Done SHALL be 0.
REQ-026: ParallelOut SHALL hold its value between completed transactions.
REQ-027: A new Start SHALL be accepted in the IDLE cycle immediately following DONE, so back-to-back transactions have a period of WIDTH+2 cycles.

Reset
REQ-028: While reset=1, the block SHALL asynchronously force state IDLE, shift register 0, counter 0, and ParallelOut 0, so that ScanOut=0, ScanEn=0, Busy=0 and Done=0.
REQ-029: Reset asserted mid-transaction SHALL abandon the transaction with no Done pulse.
REQ-030: After reset deasserts, the first Start SHALL be accepted normally.

Verification (WIDTH=8)
REQ-031: The bench SHALL apply ParallelIn=0xA5 with Start pulsed and ScanIn looped back to ScanOut -> ScanOut sequence 1,0,1,0,0,1,0,1, ScanEn high 8 cycles, Done at cycle 9, ParallelOut=0xA5.
REQ-032: The bench SHALL apply ParallelIn=0x00 with ScanIn driven 1,1,0,0,0,0,0,1 -> ParallelOut=0x83, Done exactly one cycle.
REQ-033: The bench SHALL pulse Abort at shift cycle 4 after a prior ParallelOut=0x83 -> IDLE next cycle, Busy=0, no Done, ParallelOut stays 0x83.
REQ-034: The bench SHALL hold Start high continuously -> transactions start every 10 cycles, and Start during SHIFT/DONE is ignored.
REQ-035: The bench SHALL assert Start and Abort together in IDLE -> no transaction, Busy stays 0.
REQ-036: The bench SHALL assert reset asynchronously (between clock edges) at shift cycle 5 -> all outputs 0 immediately, and ParallelOut=0.
